myproject_div_26s_10ns_16_seq: RTL
==================================

MYPROJECT_DIV_26S_10NS_16_SEQ -- requirements
Module: myproject_div_26s_10ns_16_seq

Interface
REQ-001 SHALL have parameter ID, default 32'd1, instance identifier with no functional effect.
REQ-002 SHALL have parameter NUM_STAGE, default 32'd27, informational accept-to-result latency; the design SHALL NOT vary with it.
REQ-003 SHALL have port ap_clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port ap_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port din0, input, 26, signed dividend.
REQ-006 SHALL have port din1, input, 10, unsigned divisor.
REQ-007 SHALL have port in_valid, input, 1, operands valid.
REQ-008 SHALL have port in_ready, output, 1, divider can accept operands.
REQ-009 SHALL have port dout_quot, output, 16, signed quotient, saturated.
REQ-010 SHALL have port dout_rem, output, 11, signed remainder.
REQ-011 SHALL have port dout_ovf, output, 1, quotient saturated because of overflow.
REQ-012 SHALL have port dout_dbz, output, 1, divisor was zero.
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts result.

Function
REQ-015 SHALL implement an FSM with states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept operands on an edge with in_valid=1 and in_ready=1, register |din0| as a 26-bit magnitude and the sign of din0, register din1, clear the iteration counter, and enter CALC.
REQ-017 SHALL perform one restoring-division step per CALC cycle, MSB first, for 26 cycles; on the 26th step the counter SHALL wrap to 0.
REQ-018 SHALL apply sign, saturation and flags on the edge after the 26th step, enter DONE, and assert out_valid; latency SHALL be exactly 27 edges after the accepting edge.
REQ-019 SHALL set quotient sign = sign(din0) and remainder sign = sign(din0), giving truncation toward zero.
REQ-020 SHALL set dout_ovf=1, dout_quot=32767 and dout_rem=0 when the quotient is positive and its magnitude exceeds 32767.
REQ-021 SHALL set dout_ovf=1, dout_quot=-32768 and dout_rem=0 when the quotient is negative and its magnitude exceeds 32768.
REQ-022 SHALL treat din0=-33554432 correctly, using a 26-bit unsigned magnitude with no wrap.
REQ-023 SHALL, when din1=0, set dout_dbz=1, dout_ovf=0, dout_rem=0, and dout_quot=32767 if din0>=0 or -32768 if din0<0; latency SHALL still be 27.
REQ-024 SHALL hold out_valid and all dout_* stable in DONE until out_ready=1.
REQ-025 SHALL, on the edge where out_valid=1 and out_ready=1, deassert out_valid and return to IDLE; in_ready SHALL rise in the following cycle, with no overlap of operations.
REQ-026 SHALL ignore in_valid outside IDLE and SHALL leave operands unsampled.
REQ-027 SHALL keep dout_* unchanged outside DONE, holding the last result.

Reset
REQ-028 SHALL on ap_rst=1 immediately force state=IDLE, in_ready=1 (visible once reset releases), out_valid=0, dout_quot=0, dout_rem=0, dout_ovf=0, dout_dbz=0, counter=0.
REQ-029 SHALL abandon any operation in progress when reset is asserted mid-CALC or mid-DONE, with no result emitted afterwards.

Structure
REQ-030 SHALL place widths (26, 10, 16, 11), the step count 26, the saturation limits and the FSM state enum in package myproject_div_pkg.
REQ-031 SHALL use one combinational sub-module, myproject_udiv_step, holding one restoring step: partial remainder and next dividend bit in, new partial remainder and quotient bit out.

Verification
REQ-032 SHALL check: din0=1000, din1=7 -> dout_quot=142, dout_rem=6, flags 0, out_valid exactly 27 edges after accept.
REQ-033 SHALL check: din0=-1000, din1=7 -> dout_quot=-142 (0xFF72), dout_rem=-6 (0x7FA).
REQ-034 SHALL check: din0=-32768, din1=1 -> dout_quot=-32768 and ovf=0; din0=-32769, din1=1 -> dout_quot=-32768 and ovf=1; din0=33554431, din1=1 -> dout_quot=32767, ovf=1, rem=0.
REQ-035 SHALL check: din0=500, din1=0 -> dout_quot=32767, dbz=1; din0=-5, din1=0 -> dout_quot=-32768, dbz=1.
REQ-036 SHALL check: out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0; in_valid pulsed mid-CALC -> ignored.
REQ-037 SHALL check: ap_rst asserted at CALC step 13 -> IDLE and out_valid=0 immediately; the next operation, 1000/7, completes correctly.

Source files
------------

// File: rtl/myproject_div_pkg.sv
// Shared widths, saturation limits and FSM encoding for the 26s/10u sequential divider.
package myproject_div_pkg;

  localparam int DVD_W     = 26;
  localparam int DIV_W     = 10;
  localparam int QUO_W     = 16;
  localparam int REM_W     = 11;
  localparam int NUM_STEPS = 26;
  localparam int CNT_W     = 5;

  localparam logic [QUO_W-1:0] QUO_MAX     = 16'h7fff;
  localparam logic [QUO_W-1:0] QUO_MIN     = 16'h8000;
  localparam logic [DVD_W-1:0] MAG_POS_LIM = 26'd32767;
  localparam logic [DVD_W-1:0] MAG_NEG_LIM = 26'd32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Unsigned magnitude; the most negative dividend maps to 2^25 without wrapping.
  function automatic logic [DVD_W-1:0] abs_mag(input logic [DVD_W-1:0] v);
    return v[DVD_W-1] ? (~v + DVD_W'(1)) : v;
  endfunction

endpackage

// File: rtl/myproject_udiv_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; no latency, no flow control.
module myproject_udiv_step
  import myproject_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             q_out
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] diff;
  logic           unused_diff_msb;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  assign q_out   = (shifted >= {1'b0, divisor});
  // Whichever branch is taken, the result is below the divisor and fits DIV_W bits.
  assign rem_out = q_out ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
  assign unused_diff_msb = diff[DIV_W];

endmodule

// File: rtl/myproject_div_26s_10ns_16_seq.sv
// Sequential signed/unsigned divider with 16-bit saturating quotient; result 27 edges after accept.
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module myproject_div_26s_10ns_16_seq
  import myproject_div_pkg::*;
#(
  parameter ID        = 32'd1,
  parameter NUM_STAGE = 32'd27
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DVD_W-1:0]  din0,
  input  logic [DIV_W-1:0]  din1,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [QUO_W-1:0]  dout_quot,
  output logic [REM_W-1:0]  dout_rem,
  output logic              dout_ovf,
  output logic              dout_dbz,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             steps_done;
  logic [DVD_W-1:0] dvd;
  logic [DIV_W-1:0] divisor;
  logic             neg;
  logic [DIV_W-1:0] prem;
  logic [DVD_W-1:0] qmag;

  logic [DIV_W-1:0] step_rem;
  logic             step_q;

  logic [QUO_W-1:0] fin_quot;
  logic [REM_W-1:0] fin_rem;
  logic             fin_ovf;
  logic             fin_dbz;

  logic             unused_params;
  assign unused_params = ^{ID, NUM_STAGE};

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  myproject_udiv_step u_step (
    .rem_in  (prem),
    .bit_in  (dvd[DVD_W-1]),
    .divisor (divisor),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // Sign, saturation and divide-by-zero resolution on the finished magnitudes.
  always_comb begin
    fin_quot = '0;
    fin_rem  = '0;
    fin_ovf  = 1'b0;
    fin_dbz  = 1'b0;
    if (divisor == '0) begin
      fin_dbz  = 1'b1;
      fin_quot = neg ? QUO_MIN : QUO_MAX;
    end else if (!neg && (qmag > MAG_POS_LIM)) begin
      fin_ovf  = 1'b1;
      fin_quot = QUO_MAX;
    end else if (neg && (qmag > MAG_NEG_LIM)) begin
      fin_ovf  = 1'b1;
      fin_quot = QUO_MIN;
    end else if (neg) begin
      fin_quot = ~qmag[QUO_W-1:0] + QUO_W'(1);
      fin_rem  = ~{1'b0, prem} + REM_W'(1);
    end else begin
      fin_quot = qmag[QUO_W-1:0];
      fin_rem  = {1'b0, prem};
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      steps_done <= 1'b0;
      dvd        <= '0;
      divisor    <= '0;
      neg        <= 1'b0;
      prem       <= '0;
      qmag       <= '0;
      dout_quot  <= '0;
      dout_rem   <= '0;
      dout_ovf   <= 1'b0;
      dout_dbz   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dvd        <= abs_mag(din0);
            neg        <= din0[DVD_W-1];
            divisor    <= din1;
            prem       <= '0;
            qmag       <= '0;
            cnt        <= '0;
            steps_done <= 1'b0;
            state      <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (steps_done) begin
            dout_quot  <= fin_quot;
            dout_rem   <= fin_rem;
            dout_ovf   <= fin_ovf;
            dout_dbz   <= fin_dbz;
            steps_done <= 1'b0;
            state      <= ST_DONE;
          end else begin
            prem <= step_rem;
            qmag <= {qmag[DVD_W-2:0], step_q};
            dvd  <= {dvd[DVD_W-2:0], 1'b0};
            if (cnt == CNT_W'(NUM_STEPS - 1)) begin
              cnt        <= '0;
              steps_done <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
